// File: rtl/block_processor.sv
// Block-product processing element: accepts a (row, column) index pair, fetches
// row r of A and column c of B over the shared bus, and writes C[r][c] back.
module block_processor #(
    parameter int index_width     = 8,
    parameter int greek_size      = 8,
    parameter int memory_size_log = 10,
    parameter int A_BASE          = 2,
    parameter int B_BASE          = 256,
    parameter int C_BASE          = 512
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset,
    input  logic                       i_Indexes_Ready,
    input  logic [index_width-1:0]     i_Row_Index,
    input  logic [index_width-1:0]     i_Column_Index,
    input  logic [greek_size-1:0]      i_Gamma,
    input  logic [greek_size-1:0]      i_Mu,
    output logic                       o_Indexes_Received,
    output logic                       o_Grant_Request,
    input  logic                       i_Grant,
    output logic [memory_size_log-1:0] o_Memory_Address,
    input  logic [31:0]                i_Memory_Read_Data,
    output logic [31:0]                o_Memory_Write_Data,
    output logic                       o_Write_Enable,
    output logic                       o_Result_Ready
);

    typedef enum logic [3:0] {
        IDLE, ACK, REQ_READ, FETCH_A, FETCH_B, MAC, REQ_WRITE, WRITE, DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [index_width-1:0]    row_q, row_d, col_q, col_d;
    logic [greek_size-1:0]     gamma_q, gamma_d, mu_q, mu_d, k_q, k_d;
    logic [greek_size:0]       k_inc;
    logic [31:0]               acc_q, acc_d, a_op_q, a_op_d, product;

    logic                      ack_d, req_d, we_d, ready_d;
    logic [memory_size_log-1:0] addr_d, a_addr, b_addr, c_addr;
    logic [31:0]               wdata_d;

    // Low 32 bits of a two's-complement product equal those of the unsigned one.
    assign product = a_op_q * i_Memory_Read_Data;
    assign k_inc   = {1'b0, k_q} + 1'b1;

    assign a_addr = memory_size_log'(32'(A_BASE) + 32'(row_q) * 32'(gamma_q) + 32'(k_d));
    assign b_addr = memory_size_log'(32'(B_BASE) + 32'(k_d) * 32'(mu_q) + 32'(col_q));
    assign c_addr = memory_size_log'(32'(C_BASE) + 32'(row_q) * 32'(mu_q) + 32'(col_q));

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        gamma_d = gamma_q;
        mu_d    = mu_q;
        k_d     = k_q;
        acc_d   = acc_q;
        a_op_d  = a_op_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (i_Indexes_Ready) begin
                    row_d   = i_Row_Index;
                    col_d   = i_Column_Index;
                    gamma_d = i_Gamma;
                    mu_d    = i_Mu;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = ACK;
                end
            end
            ACK: state_d = REQ_READ;
            REQ_READ: begin
                if (gamma_q == '0) state_d = REQ_WRITE;
                else if (i_Grant)  state_d = FETCH_A;
            end
            FETCH_A: state_d = i_Grant ? FETCH_B : REQ_READ;
            FETCH_B: begin
                if (i_Grant) begin
                    a_op_d  = i_Memory_Read_Data;
                    state_d = MAC;
                end else begin
                    state_d = REQ_READ;
                end
            end
            MAC: begin
                acc_d   = acc_q + product;
                k_d     = k_inc[greek_size-1:0];
                state_d = (k_inc == {1'b0, gamma_q}) ? REQ_WRITE : FETCH_A;
            end
            REQ_WRITE: if (i_Grant) state_d = WRITE;
            WRITE:     state_d = DONE;
            default:   state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        ack_d   = (state_d == ACK);
        req_d   = state_d inside {REQ_READ, FETCH_A, FETCH_B, MAC, REQ_WRITE, WRITE};
        we_d    = (state_d == WRITE);
        ready_d = (state_d == DONE);
        addr_d  = '0;
        wdata_d = '0;
        case (state_d)
            FETCH_A: addr_d = a_addr;
            FETCH_B: addr_d = b_addr;
            WRITE: begin
                addr_d  = c_addr;
                wdata_d = acc_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (i_Reset) begin
            state_q             <= IDLE;
            row_q               <= '0;
            col_q               <= '0;
            gamma_q             <= '0;
            mu_q                <= '0;
            k_q                 <= '0;
            acc_q               <= '0;
            a_op_q              <= '0;
            o_Indexes_Received  <= 1'b0;
            o_Grant_Request     <= 1'b0;
            o_Write_Enable      <= 1'b0;
            o_Result_Ready      <= 1'b0;
            o_Memory_Address    <= '0;
            o_Memory_Write_Data <= '0;
        end else begin
            state_q             <= state_d;
            row_q               <= row_d;
            col_q               <= col_d;
            gamma_q             <= gamma_d;
            mu_q                <= mu_d;
            k_q                 <= k_d;
            acc_q               <= acc_d;
            a_op_q              <= a_op_d;
            o_Indexes_Received  <= ack_d;
            o_Grant_Request     <= req_d;
            o_Write_Enable      <= we_d;
            o_Result_Ready      <= ready_d;
            o_Memory_Address    <= addr_d;
            o_Memory_Write_Data <= wdata_d;
        end
    end

endmodule
